// File: rtl/data_mem_uart_tx.sv
// data_mem_uart_tx: reads a contiguous block of data memory and sends each word
// over an 8N1 UART line, least-significant byte first.
module data_mem_uart_tx #(
    parameter int DATA_MEM_WIDTH = 24,
    parameter int DATA_MEM_ADDR_WIDTH = 12,
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic                           clk,
    input  logic                           rstN,
    input  logic                           start,
    input  logic [DATA_MEM_ADDR_WIDTH-1:0] startAddr,
    input  logic [DATA_MEM_ADDR_WIDTH:0]   wordCount,
    output logic [DATA_MEM_ADDR_WIDTH-1:0] memAddr,
    input  logic [DATA_MEM_WIDTH-1:0]      memRdData,
    output logic                           tx,
    output logic                           busy,
    output logic                           done
);
    localparam int BYTES_PER_WORD = (DATA_MEM_WIDTH + 7) / 8;
    localparam int BUF_W = BYTES_PER_WORD * 8;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BYTE_W = BYTES_PER_WORD > 1 ? $clog2(BYTES_PER_WORD) : 1;
    localparam int WC_W = DATA_MEM_ADDR_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} stateT;

    stateT              state;
    logic [CNT_W-1:0]   baudCnt;
    logic [2:0]         bitIdx;
    logic [BYTE_W-1:0]  byteIdx;
    logic [WC_W-1:0]    wordsLeft;
    logic [BUF_W-1:0]   wordBuf;
    logic               bitEnd;

    assign bitEnd = baudCnt == CNT_W'(CLKS_PER_BIT - 1);
    assign busy = state != IDLE;

    // tx is updated on the same edge as the state change, so the line always
    // reflects the bit belonging to the state just entered.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state     <= IDLE;
            memAddr   <= '0;
            tx        <= 1'b1;
            done      <= 1'b0;
            baudCnt   <= '0;
            bitIdx    <= '0;
            byteIdx   <= '0;
            wordsLeft <= '0;
            wordBuf   <= '0;
        end else begin
            done    <= 1'b0;
            baudCnt <= (state inside {START, DATA, STOP}) && !bitEnd ? baudCnt + 1'b1 : '0;
            case (state)
                IDLE: if (start) begin
                    memAddr   <= startAddr;
                    wordsLeft <= wordCount;
                    if (wordCount == '0) done <= 1'b1;
                    else state <= FETCH;
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    wordBuf <= BUF_W'(memRdData);
                    byteIdx <= '0;
                    bitIdx  <= '0;
                    tx      <= 1'b0;
                    state   <= START;
                end
                // The buffer shifts right one bit per data bit, so bytes leave LSB first.
                START: if (bitEnd) begin
                    tx      <= wordBuf[0];
                    wordBuf <= wordBuf >> 1;
                    state   <= DATA;
                end
                DATA: if (bitEnd) begin
                    if (bitIdx == 3'd7) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        tx      <= wordBuf[0];
                        wordBuf <= wordBuf >> 1;
                        bitIdx  <= bitIdx + 1'b1;
                    end
                end
                STOP: if (bitEnd) begin
                    if (byteIdx != BYTE_W'(BYTES_PER_WORD - 1)) begin
                        byteIdx <= byteIdx + 1'b1;
                        bitIdx  <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end else if (wordsLeft != WC_W'(1)) begin
                        wordsLeft <= wordsLeft - 1'b1;
                        memAddr   <= memAddr + 1'b1;
                        state     <= FETCH;
                    end else begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/data_mem_uart_tx.md
# data_mem_uart_tx

Result read-out engine for the multi-core processor system: after the processor reports done, it reads a contiguous range of the shared data memory and serialises every word over a UART TX line, least-significant byte first. It is the outbound counterpart of the UART memory loader. While active it owns the data-memory address bus through the top-level state mux, and it never writes memory.

## Interface
- DATA_MEM_WIDTH, 24: data-memory word width (CORE_COUNT × REG_WIDTH). Any width ≥ 1 is legal.
- DATA_MEM_ADDR_WIDTH, 12: data-memory address width.
- CLKS_PER_BIT, 5208: clock cycles per UART bit (50 MHz / 9600 baud). Must be ≥ 2.
- BYTES_PER_WORD, derived as ceil(DATA_MEM_WIDTH/8): bytes sent per word.

- clk  in  1  system clock; all logic is on the rising edge.
- rstN  in  1  synchronous, active-low reset.
- start  in  1  sampled high in IDLE begins a transfer. Ignored in every other state.
- startAddr  in  DATA_MEM_ADDR_WIDTH  first word address, captured with start.
- wordCount  in  DATA_MEM_ADDR_WIDTH+1  number of words to send, captured with start. 0 is legal.
- memAddr  out  DATA_MEM_ADDR_WIDTH  data-memory read address (registered).
- memRdData  in  DATA_MEM_WIDTH  data-memory output. The RAM read is synchronous, so data is valid one cycle after memAddr.
- tx  out  1  UART serial line, 8N1, idle high (registered).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- Reset values: tx=1, busy=0, done=0, memAddr=0. All counters are cleared and the state is IDLE.
- IDLE
  - On start=1, latch startAddr into memAddr and wordCount into the remaining-word counter.
  - If wordCount≠0, go to FETCH.
  - If wordCount=0, pulse done on the next cycle, stay in IDLE, and keep tx high.
- FETCH: hold one cycle for the RAM read latency, then go to LOAD.
- LOAD
  - Capture memRdData, zero-extended to BYTES_PER_WORD×8 bits, into the word buffer.
  - Clear the byte index and go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA. Bit index = 0.
- DATA
  - tx = current byte bit[bitIdx], LSB first, each bit held CLKS_PER_BIT cycles.
  - After bit 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then:
  - If more bytes remain in the word, increment the byte index and go to START. There is no extra idle cycle.
  - Else, if words remain, decrement the word counter, increment memAddr, and go to FETCH.
  - Else, pulse done and go to IDLE.
- Byte order: byte 0 = word[7:0], byte 1 = word[15:8], and so on.
- Address arithmetic is modulo 2^DATA_MEM_ADDR_WIDTH. A range that runs past the top of memory wraps to address 0.
- The baud counter counts 0..CLKS_PER_BIT-1 and resets at every bit boundary.
- Reset mid-transfer: on the next edge, tx=1, busy=0, the state is IDLE, and no done pulse is produced.
- start while busy: ignored; the latched startAddr and wordCount are unchanged.

## Timing
- Start at edge N: busy=1 and the state is FETCH from N+1. LOAD is at N+2, and tx falls at N+3.
- Each frame is 10×CLKS_PER_BIT cycles. Frames within one word are back-to-back.
- Between words, tx stays high for 2 extra cycles (FETCH + LOAD).
- done is high for exactly one cycle, the cycle after the final stop bit. busy falls in the same cycle that done rises.
- Total cycles from the start edge to the done pulse = W×(2 + BYTES_PER_WORD×10×CLKS_PER_BIT) + 1, where W = wordCount.
- memAddr is stable from FETCH through the end of that word's last STOP.

## Test plan
Benches run with CLKS_PER_BIT=4 and DATA_MEM_WIDTH=24, using a DATA_RAM model with 1-cycle read latency.
- Single word: mem[5]=0xABCDEF, start with startAddr=5, wordCount=1.
  - tx carries frames 0xEF, 0xCD, 0xAB, each 0 + LSB-first bits + 1.
  - done arrives 123 cycles after the start edge.
- Multi-word: mem[0..2]=0x000001, 0x123456, 0xFFFFFF, wordCount=3.
  - Decoded bytes are 01 00 00 56 34 12 FF FF FF.
  - The gap between words is 2 high cycles, and memAddr steps 0→1→2.
- Wrap: startAddr=4095, wordCount=2. memAddr reads 4095, then 0, and both words are transmitted.
- wordCount=0: done pulses the next cycle, busy stays 0, and tx stays 1.
- Start while busy: a second start pulse mid-frame with different startAddr/wordCount has no effect, and the byte stream is unchanged.
- Reset mid-frame: drop rstN during DATA.
  - tx=1, busy=0, and done=0 on the next edge.
  - A following start behaves normally.
